// File: rtl/aes_dec_regs_pkg.sv
// Shared definitions for the AES decrypt AXI4-Lite register block:
// register offsets, control/status bit positions, response codes, FSM states.
package aes_dec_regs_pkg;

    // Byte offsets inside the 64-byte register window
    localparam logic [5:0] OFF_KEY0     = 6'h00;
    localparam logic [5:0] OFF_CT0      = 6'h10;
    localparam logic [5:0] OFF_CTRL     = 6'h20;
    localparam logic [5:0] OFF_STATUS   = 6'h24;
    localparam logic [5:0] OFF_IRQ_STAT = 6'h28;
    localparam logic [5:0] OFF_UNMAPPED = 6'h2C;
    localparam logic [5:0] OFF_PT0      = 6'h30;

    // Word indices (byte offset / 4) used by the decoders
    localparam logic [3:0] WIDX_CTRL     = OFF_CTRL[5:2];
    localparam logic [3:0] WIDX_STATUS   = OFF_STATUS[5:2];
    localparam logic [3:0] WIDX_IRQ_STAT = OFF_IRQ_STAT[5:2];
    localparam logic [3:0] WIDX_UNMAPPED = OFF_UNMAPPED[5:2];

    // Bit positions
    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IE_BIT     = 1;
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;
    localparam int IRQ_PEND_BIT    = 0;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Core sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Merge a 32-bit write into an existing word, byte lane by byte lane
    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_dec_axil_regs.sv
// AXI4-Lite register front end for an AES decrypt core: key/ciphertext
// registers, start/done sequencing, plaintext capture and a level interrupt.
module aes_dec_axil_regs
    import aes_dec_regs_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    // write address / data / response
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    // read address / data
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    // AES core side
    output logic [127:0]                      core_key,
    output logic [127:0]                      core_ct,
    output logic                              core_start,
    input  logic                              core_done,
    input  logic [127:0]                      core_pt,
    output logic                              irq
);

    // Handshake / response registers
    logic        awready_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    logic        arready_q;
    logic        rvalid_q;
    logic [1:0]  rresp_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]  rresp_d;

    // Register file and sequencing state
    logic [127:0] key_q, ct_q, pt_q;
    logic         ie_q;
    logic         pending_q;
    state_e       state_q;
    logic         core_start_q;

    // Address decode (register window is word addressed; byte lanes via WSTRB)
    logic [3:0] wword, rword;
    logic       wr_hs, rd_hs;
    logic       wr_unmapped, wr_keyct_busy, wr_err, wr_en;
    logic       start_req, w1c_req, done_evt;
    logic       unused_addr_lsbs;

    assign wword            = S_AXI_AWADDR[5:2];
    assign rword            = S_AXI_ARADDR[5:2];
    assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign wr_hs         = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_hs         = arready_q & S_AXI_ARVALID;
    assign wr_unmapped   = (wword == WIDX_UNMAPPED);
    // KEY and CT occupy word indices 0..7; they are frozen while the core runs
    assign wr_keyct_busy = (wword[3] == 1'b0) && (state_q == ST_BUSY);
    assign wr_err        = wr_unmapped | wr_keyct_busy;
    assign wr_en         = wr_hs & ~wr_err;
    assign start_req     = wr_en && (wword == WIDX_CTRL) && S_AXI_WSTRB[0]
                           && S_AXI_WDATA[CTRL_START_BIT];
    assign w1c_req       = wr_en && (wword == WIDX_IRQ_STAT) && S_AXI_WSTRB[0]
                           && S_AXI_WDATA[IRQ_PEND_BIT];
    assign done_evt      = (state_q == ST_BUSY) && core_done;

    // Extract 32-bit word idx of a 128-bit value, word 0 being the MSW
    function automatic logic [31:0] word_of(input logic [127:0] v, input logic [1:0] idx);
        return v[32*(3 - int'(idx)) +: 32];
    endfunction

    // Read data mux: samples register contents before any same-edge write
    always_comb begin
        rdata_d = '0;
        rresp_d = RESP_OKAY;
        case (rword)
            4'h0, 4'h1, 4'h2, 4'h3: rdata_d = word_of(key_q, rword[1:0]);
            4'h4, 4'h5, 4'h6, 4'h7: rdata_d = word_of(ct_q, rword[1:0]);
            WIDX_CTRL:     rdata_d[CTRL_IE_BIT] = ie_q;
            WIDX_STATUS: begin
                rdata_d[STATUS_BUSY_BIT] = (state_q == ST_BUSY);
                rdata_d[STATUS_DONE_BIT] = (state_q == ST_DONE);
            end
            WIDX_IRQ_STAT: rdata_d[IRQ_PEND_BIT] = pending_q;
            WIDX_UNMAPPED: rresp_d = RESP_SLVERR;
            4'hC, 4'hD, 4'hE, 4'hF: rdata_d = word_of(pt_q, rword[1:0]);
            default: rdata_d = '0;
        endcase
    end

    // Write channel: single-cycle AW/W accept, response held until BREADY
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            awready_q <= ~awready_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
            if (wr_hs) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Read channel: single-cycle AR accept, data/resp held until RREADY
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            arready_q <= ~arready_q & S_AXI_ARVALID & ~rvalid_q;
            if (rd_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdata_d;
                rresp_q  <= rresp_d;
            end else if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Software-visible registers: KEY/CT with byte enables, IE, pending (set wins over W1C)
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            key_q     <= '0;
            ct_q      <= '0;
            ie_q      <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr_en && wword == 4'(i))
                    key_q[32*(3-i) +: 32] <= apply_strb(key_q[32*(3-i) +: 32], S_AXI_WDATA, S_AXI_WSTRB);
                if (wr_en && wword == 4'(i + 4))
                    ct_q[32*(3-i) +: 32] <= apply_strb(ct_q[32*(3-i) +: 32], S_AXI_WDATA, S_AXI_WSTRB);
            end
            if (wr_en && wword == WIDX_CTRL && S_AXI_WSTRB[0])
                ie_q <= S_AXI_WDATA[CTRL_IE_BIT];
            if (done_evt && ie_q)
                pending_q <= 1'b1;
            else if (w1c_req)
                pending_q <= 1'b0;
        end
    end

    // Core sequencing FSM with registered start pulse and plaintext capture
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= ST_IDLE;
            core_start_q <= 1'b0;
            pt_q         <= '0;
        end else begin
            core_start_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_req) begin
                        state_q      <= ST_BUSY;
                        core_start_q <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (core_done) begin
                        state_q <= ST_DONE;
                        pt_q    <= core_pt;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign core_key      = key_q;
    assign core_ct       = ct_q;
    assign core_start    = core_start_q;
    assign irq           = pending_q & ie_q;

endmodule

// File: tb/tb_aes_dec_axil_regs.sv
// Directed bench for aes_dec_axil_regs with a response scoreboard.
module tb_aes_dec_axil_regs;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic [5:0]   S_AXI_AWADDR;
    logic         S_AXI_AWVALID;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA;
    logic [3:0]   S_AXI_WSTRB;
    logic         S_AXI_WVALID;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY;
    logic [5:0]   S_AXI_ARADDR;
    logic         S_AXI_ARVALID;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY;
    logic [127:0] core_key;
    logic [127:0] core_ct;
    logic         core_start;
    logic         core_done;
    logic [127:0] core_pt;
    logic         irq;

    int checks = 0;
    int errors = 0;
    logic [1:0]  bexp_q[$];
    logic [33:0] rexp_q[$];
    logic        start_seen;

    always #5 ACLK = ~ACLK;

    aes_dec_axil_regs dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY),
        .core_key(core_key), .core_ct(core_ct), .core_start(core_start),
        .core_done(core_done), .core_pt(core_pt), .irq(irq)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // One write; optionally pulses core_done on the handshake edge
    task automatic axi_write(input string tag, input logic [5:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] er, input bit done_at_hs);
        int n;
        logic [1:0] e;
        bexp_q.push_back(er);
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        n = 0;
        while (!S_AXI_AWREADY && n < 20) begin tick(); n++; end
        check({tag, "_awready"}, 128'(S_AXI_AWREADY & S_AXI_WREADY), 128'(1));
        if (done_at_hs) core_done = 1'b1;
        tick();
        core_done = 1'b0;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        start_seen = core_start;
        n = 0;
        while (!S_AXI_BVALID && n < 20) begin tick(); n++; end
        check({tag, "_bvalid"}, 128'(S_AXI_BVALID), 128'(1));
        e = bexp_q.pop_front();
        check({tag, "_bresp"}, 128'(S_AXI_BRESP), 128'(e));
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
    endtask

    // One read; optionally stalls RREADY for hold cycles checking RDATA stability
    task automatic axi_read(input string tag, input logic [5:0] a, input logic [31:0] ed,
                            input logic [1:0] er, input int hold);
        int n;
        logic [33:0] e;
        rexp_q.push_back({er, ed});
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
        n = 0;
        while (!S_AXI_ARREADY && n < 20) begin tick(); n++; end
        check({tag, "_arready"}, 128'(S_AXI_ARREADY), 128'(1));
        tick();
        S_AXI_ARVALID = 1'b0;
        n = 0;
        while (!S_AXI_RVALID && n < 20) begin tick(); n++; end
        check({tag, "_rvalid"}, 128'(S_AXI_RVALID), 128'(1));
        e = rexp_q.pop_front();
        check({tag, "_rdata"}, 128'(S_AXI_RDATA), 128'(e[31:0]));
        check({tag, "_rresp"}, 128'(S_AXI_RRESP), 128'(e[33:32]));
        for (int k = 0; k < hold; k++) begin
            tick();
            check({tag, "_hold"}, 128'({S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA}), 128'({1'b1, e}));
        end
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic pulse_done(input logic [127:0] pt);
        core_pt = pt;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
    endtask

    initial begin
        logic [127:0] key_v, ct_v, pt_v;
        int n;
        key_v = 128'h00010203_04050607_08090A0B_0C0D0E0F;
        ct_v  = 128'h11111111_22222222_33333333_44BB44DD;
        pt_v  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        ARESET = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
        S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0; S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0; core_done = 1'b0; core_pt = '0; start_seen = 1'b0;
        repeat (3) tick();
        check("reset_outputs", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID,
                                     S_AXI_RVALID, core_start, irq, S_AXI_BRESP, S_AXI_RRESP}), 128'(0));
        check("reset_rdata", 128'(S_AXI_RDATA), 128'(0));
        check("reset_core_key", core_key, 128'(0));
        ARESET = 1'b0;
        tick();
        axi_read("status_idle", 6'h24, 32'h0, 2'b00, 0);

        // Key load and readback
        for (int i = 0; i < 4; i++)
            axi_write("key_wr", 6'(4*i), key_v[32*(3-i) +: 32], 4'hF, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++)
            axi_read("key_rd", 6'(4*i), key_v[32*(3-i) +: 32], 2'b00, 0);
        check("core_key", core_key, key_v);

        // Ciphertext load with a partial-strobe update of CT3
        axi_write("ct0_wr", 6'h10, 32'h11111111, 4'hF, 2'b00, 1'b0);
        axi_write("ct1_wr", 6'h14, 32'h22222222, 4'hF, 2'b00, 1'b0);
        axi_write("ct2_wr", 6'h18, 32'h33333333, 4'hF, 2'b00, 1'b0);
        axi_write("ct3_wr", 6'h1C, 32'h44444444, 4'hF, 2'b00, 1'b0);
        axi_write("ct3_strb", 6'h1C, 32'hAABBCCDD, 4'b0101, 2'b00, 1'b0);
        axi_read("ct3_rd", 6'h1C, 32'h44BB44DD, 2'b00, 0);
        check("core_ct", core_ct, ct_v);

        // Start with IE, then completion
        axi_write("ctrl_start", 6'h20, 32'h3, 4'hF, 2'b00, 1'b0);
        check("start_pulse", 128'(start_seen), 128'(1));
        check("start_one_cycle", 128'(core_start), 128'(0));
        axi_read("status_busy", 6'h24, 32'h1, 2'b00, 0);
        axi_read("ctrl_rd", 6'h20, 32'h2, 2'b00, 0);
        check("irq_busy", 128'(irq), 128'(0));
        pulse_done(pt_v);
        check("irq_done", 128'(irq), 128'(1));
        for (int i = 0; i < 4; i++)
            axi_read("pt_rd", 6'(6'h30 + 4*i), pt_v[32*(3-i) +: 32], 2'b00, 0);
        axi_read("status_done", 6'h24, 32'h2, 2'b00, 0);
        axi_read("irq_stat", 6'h28, 32'h1, 2'b00, 0);

        // core_done outside BUSY must not touch PT
        pulse_done({128{1'b1}});
        axi_read("pt0_ignored", 6'h30, 32'h00112233, 2'b00, 0);

        // Second run: writes while BUSY
        axi_write("ctrl_restart", 6'h20, 32'h3, 4'hF, 2'b00, 1'b0);
        check("restart_pulse", 128'(start_seen), 128'(1));
        axi_read("status_rebusy", 6'h24, 32'h1, 2'b00, 0);
        axi_write("ct0_busy", 6'h10, 32'hDEADBEEF, 4'hF, 2'b10, 1'b0);
        check("ct0_busy_nostart", 128'(start_seen), 128'(0));
        axi_read("ct0_kept", 6'h10, 32'h11111111, 2'b00, 0);
        axi_write("key0_busy", 6'h00, 32'hFFFFFFFF, 4'hF, 2'b10, 1'b0);
        check("core_key_stable", core_key, key_v);
        axi_write("ctrl_busy_start", 6'h20, 32'h1, 4'hF, 2'b00, 1'b0);
        check("no_second_start", 128'(start_seen), 128'(0));
        check("irq_ie_off", 128'(irq), 128'(0));
        axi_write("ctrl_ie_on", 6'h20, 32'h2, 4'hF, 2'b00, 1'b0);
        check("irq_ie_on", 128'(irq), 128'(1));

        // W1C coincident with completion: set wins
        core_pt = ~pt_v;
        axi_write("w1c_vs_set", 6'h28, 32'h1, 4'hF, 2'b00, 1'b1);
        check("irq_set_wins", 128'(irq), 128'(1));
        axi_read("status_done2", 6'h24, 32'h2, 2'b00, 0);
        axi_read("pt3_second", 6'h3C, ~pt_v[31:0], 2'b00, 0);
        axi_write("w1c_nostrb", 6'h28, 32'h1, 4'b1110, 2'b00, 1'b0);
        check("irq_nostrb", 128'(irq), 128'(1));
        axi_write("w1c", 6'h28, 32'h1, 4'hF, 2'b00, 1'b0);
        check("irq_cleared", 128'(irq), 128'(0));
        axi_read("irq_stat_clr", 6'h28, 32'h0, 2'b00, 0);

        // Unmapped and read-only accesses
        axi_read("unmapped_rd", 6'h2C, 32'h0, 2'b10, 5);
        axi_write("unmapped_wr", 6'h2C, 32'hFFFFFFFF, 4'hF, 2'b10, 1'b0);
        axi_write("status_wr", 6'h24, 32'hFFFFFFFF, 4'hF, 2'b00, 1'b0);
        axi_write("pt0_wr", 6'h30, 32'h0, 4'hF, 2'b00, 1'b0);
        axi_read("status_ro", 6'h24, 32'h2, 2'b00, 0);
        axi_read("pt0_ro", 6'h30, ~pt_v[127:96], 2'b00, 0);

        // Simultaneous read and write of KEY0 returns the old value
        bexp_q.push_back(2'b00);
        rexp_q.push_back({2'b00, key_v[127:96]});
        S_AXI_AWADDR = 6'h00; S_AXI_WDATA = 32'hCAFEF00D; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 6'h00; S_AXI_ARVALID = 1'b1;
        n = 0;
        while (!(S_AXI_AWREADY && S_AXI_ARREADY) && n < 20) begin tick(); n++; end
        check("rw_same_ready", 128'({S_AXI_AWREADY, S_AXI_ARREADY}), 128'(2'b11));
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        begin
            logic [33:0] re;
            logic [1:0]  be;
            re = rexp_q.pop_front();
            be = bexp_q.pop_front();
            check("rw_rvalid_bvalid", 128'({S_AXI_RVALID, S_AXI_BVALID}), 128'(2'b11));
            check("rw_pre_write", 128'({S_AXI_RRESP, S_AXI_RDATA}), 128'(re));
            check("rw_bresp", 128'(S_AXI_BRESP), 128'(be));
        end
        S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
        axi_read("rw_post_write", 6'h00, 32'hCAFEF00D, 2'b00, 0);

        // Reset while BUSY, with a write left hanging
        axi_write("ctrl_start3", 6'h20, 32'h3, 4'hF, 2'b00, 1'b0);
        pulse_done(pt_v);
        axi_write("ctrl_start4", 6'h20, 32'h3, 4'hF, 2'b00, 1'b0);
        S_AXI_AWADDR = 6'h10; S_AXI_WDATA = 32'h12345678; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        tick();
        ARESET = 1'b1;
        #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        check("rst_async_outputs", 128'({S_AXI_AWREADY, S_AXI_BVALID, core_start, irq}), 128'(0));
        tick();
        ARESET = 1'b0;
        repeat (3) tick();
        check("rst_no_bvalid", 128'({S_AXI_BVALID, S_AXI_RVALID}), 128'(0));
        axi_read("rst_status", 6'h24, 32'h0, 2'b00, 0);
        check("rst_irq", 128'(irq), 128'(0));
        for (int i = 0; i < 4; i++) begin
            axi_read("rst_key", 6'(4*i), 32'h0, 2'b00, 0);
            axi_read("rst_ct", 6'(6'h10 + 4*i), 32'h0, 2'b00, 0);
            axi_read("rst_pt", 6'(6'h30 + 4*i), 32'h0, 2'b00, 0);
        end
        check("rst_core_regs", {core_key ^ core_ct}, 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case a sequence stalls beyond its bounded waits
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/aes_dec_axil_regs.md
AES_DEC_AXIL_REGS -- requirements
Module: aes_dec_axil_regs

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, default 6, byte address width (64-byte register window).
REQ-003 ACLK  in  1  single clock; all logic rising-edge.
REQ-004 ARESET  in  1  reset, asynchronous, active-high.
REQ-005 S_AXI_AWADDR/AWVALID/AWREADY  in/in/out  6/1/1  write address channel (AWPROT ignored).
REQ-006 S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel.
REQ-007 S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response.
REQ-008 S_AXI_ARADDR/ARVALID/ARREADY  in/in/out  6/1/1  read address.
REQ-009 S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data.
REQ-010 core_key, core_ct  out  128 each  key and ciphertext to the AES decrypt core.
REQ-011 core_start  out  1  one-cycle start pulse to core.
REQ-012 core_done, core_pt  in  1/128  core completion pulse and plaintext.
REQ-013 irq  out  1  level interrupt.

Function
REQ-014 Map: 0x00-0x0C KEY0-3 RW; 0x10-0x1C CT0-3 RW; 0x20 CTRL; 0x24 STATUS RO; 0x28 IRQ_STAT W1C; 0x30-0x3C PT0-3 RO; 0x2C unmapped.
REQ-015 Word 0 is most significant: KEY0 = core_key[127:96], KEY3 = core_key[31:0]; same for CT and PT.
REQ-016 CTRL bit0 START write-1 (reads 0); bit1 IE RW; other bits read 0.
REQ-017 STATUS bit0 BUSY, bit1 DONE; IRQ_STAT bit0 pending.
REQ-018 Writes: AWREADY and WREADY assert together for one cycle only when AWVALID, WVALID high and BVALID low; BVALID next cycle, held until BREADY.
REQ-019 Reads: ARREADY asserts one cycle when ARVALID high and RVALID low; RVALID next cycle; RDATA/RRESP stable until RREADY.
REQ-020 Read and write channels independent; simultaneous read and write of same register returns pre-write value.
REQ-021 WSTRB honoured per byte on KEY, CT, CTRL[1]; START and W1C use byte 0 only.
REQ-022 Any access to 0x2C: BRESP/RRESP = SLVERR (2'b10), RDATA 0, no state change; all others OKAY.
REQ-023 Writes to KEY/CT while BUSY ignored and answered SLVERR; writes to RO registers ignored, OKAY.
REQ-024 FSM states IDLE, BUSY, DONE; reset to IDLE.
REQ-025 IDLE/DONE + START write -> core_start high exactly the cycle after write handshake, BUSY, DONE bit cleared.
REQ-026 BUSY + START write ignored (no pulse).
REQ-027 BUSY + core_done -> PT0-3 capture core_pt same edge, state DONE; core_done outside BUSY ignored.
REQ-028 On BUSY->DONE with IE=1, pending sets; irq = pending & IE.
REQ-029 W1C to pending in the same cycle as set: set wins.
REQ-030 core_key/core_ct are the register contents, stable throughout BUSY.

Reset
REQ-031 On ARESET: all registers 0, FSM IDLE, AWREADY/WREADY/ARREADY/BVALID/RVALID/core_start/irq 0, BRESP/RRESP 0, RDATA 0.
REQ-032 Reset mid-transaction abandons it; no response issued after release.

Structure
REQ-033 Package aes_dec_regs_pkg holds register offsets, CTRL/STATUS bit indices, RESP codes, FSM state enum.
REQ-034 Flat single module, no sub-module.

Verification
REQ-035 Write KEY0-3 = 0x000102030405060708090A0B0C0D0E0F words, read back -> identical data, OKAY; core_key matches.
REQ-036 Write CTRL=0x3 -> core_start one cycle, STATUS=0x1; core_done with core_pt=0x00112233_44556677_8899AABB_CCDDEEFF -> PT0=0x00112233, STATUS=0x2, irq=1.
REQ-037 Write IRQ_STAT=0x1 -> irq 0; concurrent with new completion -> irq stays 1.
REQ-038 During BUSY write CT0=0xDEADBEEF and CTRL=0x1 -> CT0 unchanged, BRESP SLVERR, no second core_start.
REQ-039 Read 0x2C -> RDATA 0, RRESP 2'b10; hold RREADY low 5 cycles -> RDATA stable.
REQ-040 Assert ARESET during BUSY -> STATUS 0, irq 0, all KEY/CT/PT read 0.
